turbo_iter_ctrl: RTL

TURBO_ITER_CTRL -- requirements
Module: turbo_iter_ctrl

---
 rtl/turbo_pkg.sv | 29 ++
 rtl/turbo_iter_ctrl_if.sv | 35 +++
 rtl/siso_watchdog.sv | 32 +++
 rtl/turbo_iter_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/turbo_pkg.sv
// Shared types and constants for the turbo decoder iteration controller.
// The FSM encoding, SISO select codes and width helpers live here.
package turbo_pkg;

  localparam int LLR_BITS_DEF     = 16;
  localparam int MAX_ITER_DEF     = 8;
  localparam int SISO_TIMEOUT_DEF = 64;

  localparam logic SISO_SEL_D1 = 1'b0;
  localparam logic SISO_SEL_D2 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN_D1  = 3'd1,
    ST_WAIT_D1 = 3'd2,
    ST_RUN_D2  = 3'd3,
    ST_WAIT_D2 = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int iter_width(input int max_iter);
    return $clog2(max_iter + 1);
  endfunction

  function automatic bit llr_bits_ok(input int bits);
    return (bits >= 2) && (bits <= 32);
  endfunction

endpackage

// File: rtl/turbo_iter_ctrl_if.sv
// Frame request, SISO handshake and extrinsic-buffer strobe bundle.
// master = iteration controller, slave = frame source / SISO / buffer side.
interface turbo_iter_ctrl_if
  import turbo_pkg::*;
#(
  parameter int MAX_ITER = MAX_ITER_DEF
);
  localparam int IW = iter_width(MAX_ITER);

  logic          start;
  logic [IW-1:0] num_iter;
  logic          frame_ready;
  logic          busy;
  logic          siso_in_valid;
  logic          siso_sel;
  logic          siso_out_valid;
  logic          extr_wr_en;
  logic          extr_sel;
  logic [IW-1:0] iter_count;
  logic          done;
  logic          timeout_err;

  modport master (
    input  start, num_iter, siso_out_valid,
    output frame_ready, busy, siso_in_valid, siso_sel,
           extr_wr_en, extr_sel, iter_count, done, timeout_err
  );

  modport slave (
    output start, num_iter, siso_out_valid,
    input  frame_ready, busy, siso_in_valid, siso_sel,
           extr_wr_en, extr_sel, iter_count, done, timeout_err
  );

endinterface

// File: rtl/siso_watchdog.sv
// Counts cycles spent waiting on the SISO; expired flags the last allowed wait cycle.
module siso_watchdog
  import turbo_pkg::*;
#(
  parameter int TIMEOUT = SISO_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_r;

  // Wait-cycle counter, saturating at the last allowed cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear) begin
      cnt_r <= {CW{1'b0}};
    end else if (enable && (cnt_r != LAST)) begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign expired = enable && (cnt_r == LAST);

endmodule

// File: rtl/turbo_iter_ctrl.sv
// Turbo decoder iteration controller: sequences the shared SISO through
// decoder 1 / decoder 2 half-iterations with a per-wait watchdog.
module turbo_iter_ctrl
  import turbo_pkg::*;
#(
  parameter int BITS         = LLR_BITS_DEF,
  parameter int MAX_ITER     = MAX_ITER_DEF,
  parameter int SISO_TIMEOUT = SISO_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  turbo_iter_ctrl_if.master  bus
);

  localparam int            IW    = iter_width(MAX_ITER);
  localparam logic [IW-1:0] N_ONE = IW'(1);
  localparam logic [IW-1:0] N_MAX = IW'(MAX_ITER);

  if (!llr_bits_ok(BITS)) begin : g_bad_llr_bits
    $error("turbo_iter_ctrl: unsupported BITS value");
  end

  state_e        state_r;
  logic [IW-1:0] n_r;
  logic [IW-1:0] n_clamped_s;
  logic          wd_clear_s;
  logic          wd_enable_s;
  logic          wd_expired_s;

  logic          frame_ready_r;
  logic          busy_r;
  logic          siso_in_valid_r;
  logic          siso_sel_r;
  logic          extr_wr_en_r;
  logic          extr_sel_r;
  logic [IW-1:0] iter_count_r;
  logic          done_r;
  logic          timeout_err_r;

  // Requested iteration count: zero means one pass, excess is clamped
  always_comb begin
    n_clamped_s = bus.num_iter;
    if (bus.num_iter == {IW{1'b0}}) begin
      n_clamped_s = N_ONE;
    end else if (bus.num_iter > N_MAX) begin
      n_clamped_s = N_MAX;
    end else begin
      n_clamped_s = bus.num_iter;
    end
  end

  // Watchdog restarts on every launch and runs only while waiting
  always_comb begin
    wd_clear_s  = (state_r == ST_RUN_D1) || (state_r == ST_RUN_D2);
    wd_enable_s = (state_r == ST_WAIT_D1) || (state_r == ST_WAIT_D2);
  end

  siso_watchdog #(
    .TIMEOUT (SISO_TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear_s),
    .enable  (wd_enable_s),
    .expired (wd_expired_s)
  );

  // Controller FSM; every output is registered alongside the state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= ST_IDLE;
      n_r             <= {IW{1'b0}};
      frame_ready_r   <= 1'b1;
      busy_r          <= 1'b0;
      siso_in_valid_r <= 1'b0;
      siso_sel_r      <= SISO_SEL_D1;
      extr_wr_en_r    <= 1'b0;
      extr_sel_r      <= 1'b0;
      iter_count_r    <= {IW{1'b0}};
      done_r          <= 1'b0;
      timeout_err_r   <= 1'b0;
    end else begin
      siso_in_valid_r <= 1'b0;
      extr_wr_en_r    <= 1'b0;
      done_r          <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r         <= ST_RUN_D1;
            n_r             <= n_clamped_s;
            iter_count_r    <= N_ONE;
            siso_in_valid_r <= 1'b1;
            siso_sel_r      <= SISO_SEL_D1;
            frame_ready_r   <= 1'b0;
            busy_r          <= 1'b1;
            timeout_err_r   <= 1'b0;
          end
        end
        ST_RUN_D1: begin
          state_r <= ST_WAIT_D1;
        end
        ST_WAIT_D1: begin
          // A completion on the expiry cycle still wins over the abort
          if (bus.siso_out_valid) begin
            state_r         <= ST_RUN_D2;
            siso_in_valid_r <= 1'b1;
            siso_sel_r      <= SISO_SEL_D2;
            extr_wr_en_r    <= 1'b1;
            extr_sel_r      <= SISO_SEL_D1;
          end else if (wd_expired_s) begin
            state_r       <= ST_IDLE;
            timeout_err_r <= 1'b1;
            frame_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            iter_count_r  <= {IW{1'b0}};
            siso_sel_r    <= SISO_SEL_D1;
            extr_sel_r    <= 1'b0;
          end
        end
        ST_RUN_D2: begin
          state_r <= ST_WAIT_D2;
        end
        ST_WAIT_D2: begin
          if (bus.siso_out_valid) begin
            extr_wr_en_r <= 1'b1;
            extr_sel_r   <= SISO_SEL_D2;
            if (iter_count_r < n_r) begin
              state_r         <= ST_RUN_D1;
              iter_count_r    <= iter_count_r + N_ONE;
              siso_in_valid_r <= 1'b1;
              siso_sel_r      <= SISO_SEL_D1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else if (wd_expired_s) begin
            state_r       <= ST_IDLE;
            timeout_err_r <= 1'b1;
            frame_ready_r <= 1'b1;
            busy_r        <= 1'b0;
            iter_count_r  <= {IW{1'b0}};
            siso_sel_r    <= SISO_SEL_D1;
            extr_sel_r    <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r       <= ST_IDLE;
          frame_ready_r <= 1'b1;
          busy_r        <= 1'b0;
          iter_count_r  <= {IW{1'b0}};
          siso_sel_r    <= SISO_SEL_D1;
          extr_sel_r    <= 1'b0;
        end
        default: begin
          state_r       <= ST_IDLE;
          frame_ready_r <= 1'b1;
          busy_r        <= 1'b0;
          iter_count_r  <= {IW{1'b0}};
          siso_sel_r    <= SISO_SEL_D1;
          extr_sel_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.frame_ready   = frame_ready_r;
  assign bus.busy          = busy_r;
  assign bus.siso_in_valid = siso_in_valid_r;
  assign bus.siso_sel      = siso_sel_r;
  assign bus.extr_wr_en    = extr_wr_en_r;
  assign bus.extr_sel      = extr_sel_r;
  assign bus.iter_count    = iter_count_r;
  assign bus.done          = done_r;
  assign bus.timeout_err   = timeout_err_r;

endmodule
